// File: rtl/lsu_pkg.sv
// Shared encodings, FSM state type and the access-legality check for the load/store unit.
package lsu_pkg;

  localparam logic [1:0] SZ_B   = 2'b00;
  localparam logic [1:0] SZ_H   = 2'b01;
  localparam logic [1:0] SZ_W   = 2'b10;
  localparam logic [1:0] SZ_RSV = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    LD,
    RMW_RD,
    WR,
    RESP
  } lsu_state_t;

  // hi_nz flags byte-address bits above the memory range as non-zero.
  function automatic logic access_err(input logic [1:0] size,
                                      input logic [1:0] lo,
                                      input logic       hi_nz);
    logic e;
    e = hi_nz;
    case (size)
      SZ_RSV:  e = 1'b1;
      SZ_H:    if (lo[0]) e = 1'b1;
      SZ_W:    if (lo != 2'b00) e = 1'b1;
      default: ;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: extract+extend a load lane, and merge a store lane into a read word.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        uns,
  input  logic [15:0] wdata,
  output logic [31:0] ld_data,
  output logic [31:0] merged
);

  logic [31:0] shifted;
  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    shifted = word >> {lane, 3'b000};
    byte_v  = shifted[7:0];
    half_v  = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_B:    ld_data = {{24{~uns & byte_v[7]}}, byte_v};
      SZ_H:    ld_data = {{16{~uns & half_v[15]}}, half_v};
      default: ld_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (size)
      SZ_B:    merged[{lane, 3'b000} +: 8]      = wdata[7:0];
      SZ_H:    merged[{lane[1], 4'b0000} +: 16] = wdata;
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store unit for a word-only memory: sub-word stores via read-modify-write, extended loads.
// Optional LSU_ACCESS_CNT_EN adds saturating successful load/store counters.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int MEM_AW = 6,
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_i,
  output logic              ready_o,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic              we_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [31:0]       wdata_i,
  output logic              valid_o,
  output logic [31:0]       rdata_o,
  output logic              err_o,
  output logic [MEM_AW-1:0] mem_addr_o,
  output logic [31:0]       mem_wdata_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  input  logic [31:0]       mem_rdata_i
`ifdef LSU_ACCESS_CNT_EN
  ,
  output logic [15:0]       ld_cnt_o,
  output logic [15:0]       st_cnt_o
`endif
);

  lsu_state_t        state;
  logic [MEM_AW+1:0] addr_q;
  logic              we_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rdata_q;
  logic [31:0]       merge_q;
  logic [31:0]       ld_data;
  logic [31:0]       merged;
  logic              hi_nz;
  logic              acc_err;

`ifdef LSU_ACCESS_CNT_EN
  logic [15:0] ld_cnt;
  logic [15:0] st_cnt;
  assign ld_cnt_o = ld_cnt;
  assign st_cnt_o = st_cnt;
`endif

  assign hi_nz   = |addr_i[ADDR_W-1:MEM_AW+2];
  assign acc_err = access_err(size_i, addr_i[1:0], hi_nz);

  lsu_align u_align (
    .word    (mem_rdata_i),
    .lane    (addr_q[1:0]),
    .size    (size_q),
    .uns     (uns_q),
    .wdata   (wdata_q[15:0]),
    .ld_data (ld_data),
    .merged  (merged)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state   <= IDLE;
      addr_q  <= '0;
      we_q    <= 1'b0;
      size_q  <= SZ_B;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      merge_q <= '0;
`ifdef LSU_ACCESS_CNT_EN
      ld_cnt  <= '0;
      st_cnt  <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (req_i) begin
          addr_q  <= addr_i[MEM_AW+1:0];
          we_q    <= we_i;
          size_q  <= size_i;
          uns_q   <= unsigned_i;
          wdata_q <= wdata_i;
          rdata_q <= '0;
          err_q   <= acc_err;
          if (acc_err)           state <= RESP;
          else if (!we_i)        state <= LD;
          else if (size_i == SZ_W) state <= WR;
          else                   state <= RMW_RD;
        end
        LD: begin
          rdata_q <= ld_data;
          state   <= RESP;
`ifdef LSU_ACCESS_CNT_EN
          if (ld_cnt != 16'hFFFF) ld_cnt <= ld_cnt + 16'd1;
`endif
        end
        RMW_RD: begin
          merge_q <= merged;
          state   <= WR;
        end
        WR: begin
          state <= RESP;
`ifdef LSU_ACCESS_CNT_EN
          if (st_cnt != 16'hFFFF) st_cnt <= st_cnt + 16'd1;
`endif
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes decode the state register directly so reset removes them without waiting for a clock.
  assign ready_o     = (state == IDLE);
  assign valid_o     = (state == RESP);
  assign err_o       = (state == RESP) & err_q;
  assign rdata_o     = (state == RESP) ? rdata_q : '0;
  assign mem_read_o  = (state == LD) || (state == RMW_RD);
  assign mem_write_o = (state == WR);
  assign mem_addr_o  = (state != IDLE) ? addr_q[MEM_AW+1:2] : '0;
  assign mem_wdata_o = (state != WR) ? '0 : ((size_q == SZ_W) ? wdata_q : merge_q);

endmodule

// File: tb/tb_lsu_ctrl.sv
// Scoreboard bench for lsu_ctrl: driver queues expected responses, a monitor pops them on valid_o.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  localparam int MEM_AW = 6;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rst_ni;
  logic              req_i;
  logic              ready_o;
  logic [ADDR_W-1:0] addr_i;
  logic              we_i;
  logic [1:0]        size_i;
  logic              unsigned_i;
  logic [31:0]       wdata_i;
  logic              valid_o;
  logic [31:0]       rdata_o;
  logic              err_o;
  logic [MEM_AW-1:0] mem_addr_o;
  logic [31:0]       mem_wdata_o;
  logic              mem_write_o;
  logic              mem_read_o;
  logic [31:0]       mem_rdata_i;
`ifdef LSU_ACCESS_CNT_EN
  logic [15:0]       ld_cnt_o;
  logic [15:0]       st_cnt_o;
`endif

  logic [31:0] mem [64];

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_AW(MEM_AW), .ADDR_W(ADDR_W)) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .req_i       (req_i),
    .ready_o     (ready_o),
    .addr_i      (addr_i),
    .we_i        (we_i),
    .size_i      (size_i),
    .unsigned_i  (unsigned_i),
    .wdata_i     (wdata_i),
    .valid_o     (valid_o),
    .rdata_o     (rdata_o),
    .err_o       (err_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_write_o (mem_write_o),
    .mem_read_o  (mem_read_o),
    .mem_rdata_i (mem_rdata_i)
`ifdef LSU_ACCESS_CNT_EN
    ,
    .ld_cnt_o    (ld_cnt_o),
    .st_cnt_o    (st_cnt_o)
`endif
  );

  assign mem_rdata_i = mem[mem_addr_o];
  always @(posedge clk) if (mem_write_o) mem[mem_addr_o] <= mem_wdata_o;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t        q[$];
  int          nvec = 0;
  int          nfail = 0;
  int          wr_cnt = 0;
  int          rd_cnt = 0;
  logic [31:0] last_waddr = '0;
  logic [31:0] last_wdata = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (mem_write_o) begin
        wr_cnt++;
        last_waddr = 32'(mem_addr_o);
        last_wdata = mem_wdata_o;
      end
      if (mem_read_o) rd_cnt++;
      if (rst_ni && valid_o) begin
        if (q.size() == 0) begin
          nvec++;
          nfail++;
          $display("FAIL unexpected_valid: got valid_o=1 want no response");
        end else begin
          e = q.pop_front();
          chk("rdata", rdata_o, e.rdata);
          chk("err", {31'b0, err_o}, {31'b0, e.err});
          chk("latency", 32'(cyc - e.acc), 32'(e.lat));
        end
      end
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic w, input logic [1:0] sz,
                       input logic u, input logic [31:0] wd,
                       input logic [31:0] exp_rdata, input logic exp_err, input int lat);
    exp_t e;
    int   n;
    @(negedge clk);
    addr_i = a; we_i = w; size_i = sz; unsigned_i = u; wdata_i = wd; req_i = 1'b1;
    n = 0;
    while (!ready_o && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!ready_o) begin
      chk("ready_timeout", {31'b0, ready_o}, 32'd1);
    end else begin
      e.rdata = exp_rdata; e.err = exp_err; e.acc = cyc; e.lat = lat;
      q.push_back(e);
    end
    @(posedge clk);
    #1 req_i = 1'b0;
    n = 0;
    while (q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      chk("response_timeout", 32'(q.size()), 32'd0);
      q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, r0, n;
    fork
      monitor_loop();
    join_none

    rst_ni = 1'b0; req_i = 1'b0; addr_i = '0; we_i = 1'b0;
    size_i = SZ_B; unsigned_i = 1'b0; wdata_i = '0;
    repeat (3) @(negedge clk);
    chk("rst_ready", {31'b0, ready_o}, 32'd1);
    chk("rst_valid", {31'b0, valid_o}, 32'd0);
    chk("rst_err", {31'b0, err_o}, 32'd0);
    chk("rst_wr", {31'b0, mem_write_o}, 32'd0);
    chk("rst_rd", {31'b0, mem_read_o}, 32'd0);
    chk("rst_rdata", rdata_o, 32'd0);
    chk("rst_addr", 32'(mem_addr_o), 32'd0);
    rst_ni = 1'b1;

    issue(32'h10, 1'b1, SZ_W, 1'b0, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("sw_wr_cnt", 32'(wr_cnt), 32'd1);
    chk("sw_waddr", last_waddr, 32'd4);
    chk("sw_wdata", last_wdata, 32'hDEADBEEF);

    issue(32'h13, 1'b0, SZ_B, 1'b0, 32'h0, 32'hFFFFFFDE, 1'b0, 2);
    issue(32'h13, 1'b0, SZ_B, 1'b1, 32'h0, 32'h000000DE, 1'b0, 2);
    issue(32'h10, 1'b0, SZ_H, 1'b0, 32'h0, 32'hFFFFBEEF, 1'b0, 2);
    issue(32'h12, 1'b0, SZ_H, 1'b1, 32'h0, 32'h0000DEAD, 1'b0, 2);
    issue(32'h10, 1'b0, SZ_W, 1'b1, 32'h0, 32'hDEADBEEF, 1'b0, 2);

    issue(32'h11, 1'b1, SZ_B, 1'b0, 32'h00000055, 32'h0, 1'b0, 3);
    chk("sb_wdata", last_wdata, 32'hDEAD55EF);
    chk("sb_mem", mem[4], 32'hDEAD55EF);
    issue(32'h10, 1'b0, SZ_B, 1'b0, 32'h0, 32'hFFFFFFEF, 1'b0, 2);

    w0 = wr_cnt; r0 = rd_cnt;
    issue(32'h12, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    issue(32'h100, 1'b0, SZ_B, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    issue(32'h11, 1'b1, SZ_H, 1'b0, 32'h1234, 32'h0, 1'b1, 1);
    issue(32'h0, 1'b0, SZ_RSV, 1'b0, 32'h0, 32'h0, 1'b1, 1);
    chk("err_no_write", 32'(wr_cnt - w0), 32'd0);
    chk("err_no_read", 32'(rd_cnt - r0), 32'd0);

    issue(32'h14, 1'b1, SZ_W, 1'b0, 32'h11112222, 32'h0, 1'b0, 2);
    issue(32'h16, 1'b1, SZ_H, 1'b0, 32'h0000ABCD, 32'h0, 1'b0, 3);
    chk("sh_mem", mem[5], 32'hABCD2222);
    issue(32'h14, 1'b0, SZ_W, 1'b0, 32'h0, 32'hABCD2222, 1'b0, 2);

    // Interrupted halfword RMW: reset lands while the write strobe is up.
    @(negedge clk);
    addr_i = 32'h12; we_i = 1'b1; size_i = SZ_H; unsigned_i = 1'b0; wdata_i = 32'h7777; req_i = 1'b1;
    @(posedge clk);
    #1 req_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_write_o && n < 10);
    chk("rmw_reached_wr", {31'b0, mem_write_o}, 32'd1);
    rst_ni = 1'b0;
    #1;
    chk("rst_drops_wr", {31'b0, mem_write_o}, 32'd0);
    chk("rst_ready_now", {31'b0, ready_o}, 32'd1);
    @(negedge clk);
    chk("rst_mem_kept", mem[4], 32'hDEAD55EF);
    rst_ni = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", {31'b0, ready_o}, 32'd1);

    issue(32'h20, 1'b1, SZ_W, 1'b0, 32'h01020304, 32'h0, 1'b0, 2);
    issue(32'h21, 1'b1, SZ_B, 1'b0, 32'h000000AA, 32'h0, 1'b0, 3);
    issue(32'h20, 1'b0, SZ_W, 1'b0, 32'h0, 32'h0102AA04, 1'b0, 2);
    issue(32'h22, 1'b0, SZ_B, 1'b0, 32'h0, 32'h00000002, 1'b0, 2);
    issue(32'h16, 1'b0, SZ_H, 1'b1, 32'h0, 32'h0000ABCD, 1'b0, 2);
    issue(32'h23, 1'b0, SZ_H, 1'b0, 32'h0, 32'h0, 1'b1, 1);
`ifdef LSU_ACCESS_CNT_EN
    chk("ld_cnt", 32'(ld_cnt_o), 32'd3);
    chk("st_cnt", 32'(st_cnt_o), 32'd2);
`endif

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit directly upstream of the word-only data memory.
- Accepts byte/halfword/word load and store requests from the datapath over a req/ready handshake.
- Drives the memory's word address, write data, write strobe and read strobe, and consumes its combinational read data.
- Because the memory has no byte enables, sub-word stores are done as read-modify-write. Loads are sign- or zero-extended, and misaligned or out-of-range accesses are flagged.

Parameters:
- MEM_AW, 6: memory word-address width; addressable bytes = 4*2^MEM_AW.
- ADDR_W, 32: byte address width from the datapath.

Ports:
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  asynchronous active-low reset
- req_i  in  1  request valid
- ready_o  out  1  unit can accept a request
- addr_i  in  ADDR_W  byte address
- we_i  in  1  1 = store, 0 = load
- size_i  in  2  00 byte, 01 half, 10 word, 11 reserved
- unsigned_i  in  1  zero-extend load (LBU/LHU)
- wdata_i  in  32  store data, right-aligned
- valid_o  out  1  one-cycle completion pulse
- rdata_o  out  32  extended load data; valid while valid_o
- err_o  out  1  access error; valid while valid_o
- mem_addr_o  out  MEM_AW  word address to memory
- mem_wdata_o  out  32  write word to memory
- mem_write_o  out  1  memory write strobe
- mem_read_o  out  1  memory read strobe
- mem_rdata_i  in  32  memory read data, combinational

Behaviour:
- States: IDLE, LD, RMW_RD, WR, RESP.
- Reset (asynchronous): state goes to IDLE. All registers clear. ready_o=1; valid_o, err_o, mem_write_o, mem_read_o = 0; rdata_o = 0.
- Strobes are decoded from state only: mem_read_o = LD|RMW_RD, mem_write_o = WR. Asserting reset mid-access therefore removes the strobe immediately. An interrupted RMW never writes.
- ready_o = (state==IDLE).
- Accept on req_i & ready_o: latch addr, we, size, unsigned, wdata.
- Error on accept if any of the following holds; the access goes IDLE -> RESP with err_o=1 and no memory strobe:
  - size==11
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - addr[ADDR_W-1:MEM_AW+2] != 0
- Otherwise, on accept:
  - load -> LD
  - word store -> WR
  - byte/half store -> RMW_RD
- mem_addr_o = addr_q[MEM_AW+1:2] in all non-IDLE states; 0 in IDLE.
- LD: capture the extracted lane of mem_rdata_i, extended, into rdata_q -> RESP.
  - Byte lane = addr_q[1:0]; half lane = addr_q[1].
  - Sign-extend unless unsigned_q is set.
  - unsigned_q is ignored for word loads.
- RMW_RD: merge_q = mem_rdata_i with the target lane replaced by wdata_q[7:0] (byte) or wdata_q[15:0] (half) -> WR.
- WR: mem_wdata_o = merge_q for sub-word stores, wdata_q for word stores -> RESP. mem_wdata_o = 0 outside WR.
- RESP: valid_o=1 for exactly one cycle -> IDLE.
  - rdata_o = rdata_q for loads, 0 for stores/errors.
  - A new request can be accepted on the following IDLE cycle; no back-to-back accept in RESP.
- Latency, accept edge to valid_o: load 2 cycles, word store 2, sub-word store 3, error 1.
- req_i while not ready is ignored; the datapath must hold the request stable until ready_o.

Optional Feature:
- Macro LSU_ACCESS_CNT_EN.
- When defined: adds outputs ld_cnt_o[15:0] and st_cnt_o[15:0].
  - Each increments on entry to RESP for a successful load/store.
  - Both saturate at 16'hFFFF and reset to 0.
  - Errors are not counted.
- When undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package lsu_pkg holds:
  - size encoding constants SZ_B/SZ_H/SZ_W/SZ_RSV
  - state enum lsu_state_t
  - the error-check function
- Sub-module lsu_align (purely combinational) does lane extraction with sign/zero extension and lane merge. It is instantiated once in lsu_ctrl.

Test Plan:
- Reset, then word store addr 0x10 data 0xDEADBEEF -> mem_write_o pulses in WR with mem_addr_o=4 and mem_wdata_o=0xDEADBEEF; valid_o 2 cycles after accept, err_o=0.
- Memory word 4 = 0xDEADBEEF; LB addr 0x13 -> rdata_o=0xFFFFFFDE. LBU addr 0x13 -> 0x000000DE. LH addr 0x10 -> 0xFFFFBEEF.
- SB addr 0x11 data 0x55 onto 0xDEADBEEF -> RMW_RD then WR writes 0xDEAD55EF; valid_o 3 cycles after accept.
- LW addr 0x12 -> err_o=1 with valid_o 1 cycle after accept, no strobes. Address 0x100 with MEM_AW=6 -> also err_o=1.
- Assert rst_ni low during WR of an SH -> mem_write_o drops immediately, memory unchanged, ready_o=1 after release.
- With LSU_ACCESS_CNT_EN: 3 loads, 2 stores, 1 error -> ld_cnt_o=3, st_cnt_o=2.
